delay_line_mc: RTL and testbench

DELAY_LINE_MC -- requirements
Module: delay_line_mc

---
 rtl/delay_line_mc.sv | 190 +++++++++++++++++++
 tb/tb_delay_line_mc.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_mc.sv
// delay_line_mc: multi-channel programmable delay line for 1-bit pulse trains.
//
// Every level change on a channel is timestamped against a shared free-running
// counter and held in that channel's edge FIFO. When the age of the FIFO head
// equals the channel's delay, the head is popped and the output toggles. With
// this arrangement pulse widths are preserved exactly and many pulses can be in
// flight at once.
//
// Optional feature: define DELAY_LINE_MC_SYNC_EN to put a 2-flop synchroniser
// ahead of the input stage. Total input-to-output latency is then delay + 4
// cycles; without the macro it is delay + 2 cycles.
//
// Ports:
//   clk_in      - single clock, all logic on its rising edge
//   rst_n       - asynchronous active-low reset
//   in          - asynchronous pulse inputs, one bit per channel
//   delay_val   - new delay in cycles (0 is treated as 1)
//   delay_ch    - target channel for delay_load
//   delay_load  - one-cycle strobe: apply delay_val to delay_ch, flush its FIFO
//   ovf_clr     - one-cycle strobe: clear all sticky overflow flags
//   out         - delayed copies of in
//   ovf         - sticky per-channel FIFO overflow flags
//   led0        - activity indicator, stretched for 2^LED_W - 1 cycles
//   led1        - OR of all ovf bits
module delay_line_mc #(
    parameter int unsigned CHANNELS    = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned DELAY_RESET = 165,
    parameter int unsigned LED_W       = 24,
    localparam int unsigned CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] in,
    input  logic [CNT_W-1:0]    delay_val,
    input  logic [CH_W-1:0]     delay_ch,
    input  logic                delay_load,
    input  logic                ovf_clr,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] ovf,
    output logic                led0,
    output logic                led1
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DLY_INIT = CNT_W'(DELAY_RESET);

    logic [CNT_W-1:0]    ts_q, ts_d;
    logic [CHANNELS-1:0] stage_q, stage_d;
    logic [CHANNELS-1:0] prev_q, prev_d;
    logic [CHANNELS-1:0] edge_q, edge_d;
    logic [CHANNELS-1:0] out_q, out_d;
    logic [CHANNELS-1:0] ovf_q, ovf_d;
    logic [LED_W-1:0]    led_cnt_q, led_cnt_d;

    logic [CNT_W-1:0]    dly_q [CHANNELS];
    logic [CNT_W-1:0]    dly_d [CHANNELS];
    logic [AW:0]         wr_q  [CHANNELS];
    logic [AW:0]         wr_d  [CHANNELS];
    logic [AW:0]         rd_q  [CHANNELS];
    logic [AW:0]         rd_d  [CHANNELS];
    logic [CNT_W-1:0]    mem_q [CHANNELS][FIFO_DEPTH];
    logic [CNT_W-1:0]    age   [CHANNELS];

    logic [CHANNELS-1:0] det;
    logic [CHANNELS-1:0] empty, full;
    logic [CHANNELS-1:0] load_hit, pop, push, ovfl, flush;

`ifdef DELAY_LINE_MC_SYNC_EN
    logic [CHANNELS-1:0] sync1_q, sync2_q;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= in;
            sync2_q <= sync1_q;
        end
    end

    assign stage_d = sync2_q;
`else
    assign stage_d = in;
`endif

    always_comb begin
        ts_d   = ts_q + CNT_W'(1);
        prev_d = stage_q;
        det    = stage_q ^ prev_q;

        for (int c = 0; c < CHANNELS; c++) begin
            // Modular age of the head handles timestamp wrap for free.
            age[c]      = ts_q - mem_q[c][rd_q[c][AW-1:0]];
            empty[c]    = (wr_q[c] == rd_q[c]);
            full[c]     = (wr_q[c] == {~rd_q[c][AW], rd_q[c][AW-1:0]});
            load_hit[c] = delay_load && (delay_ch == CH_W'(c));
            pop[c]      = !empty[c] && (age[c] == dly_q[c]);
            // A same-cycle pop frees a slot, so only a pop-less push into a full
            // FIFO overflows; a delay load absorbs the edge instead.
            ovfl[c]     = edge_q[c] && full[c] && !pop[c] && !load_hit[c];
            flush[c]    = load_hit[c] || ovfl[c];
            push[c]     = edge_q[c] && !flush[c];

            wr_d[c] = flush[c] ? '0 : wr_q[c] + {{AW{1'b0}}, push[c]};
            rd_d[c] = flush[c] ? '0 : rd_q[c] + {{AW{1'b0}}, pop[c]};

            // On a flush the output snaps to the current level, which already
            // contains every edge that has reached the input stage.
            if (flush[c]) begin
                out_d[c] = stage_q[c];
            end else if (pop[c]) begin
                out_d[c] = ~out_q[c];
            end else begin
                out_d[c] = out_q[c];
            end

            if (load_hit[c]) begin
                dly_d[c] = (delay_val == '0) ? CNT_W'(1) : delay_val;
            end else begin
                dly_d[c] = dly_q[c];
            end

            if (ovfl[c]) begin
                ovf_d[c] = 1'b1;
            end else if (ovf_clr) begin
                ovf_d[c] = 1'b0;
            end else begin
                ovf_d[c] = ovf_q[c];
            end
        end

        // Edges already folded into a flushed output level must not be pushed.
        edge_d = det & ~flush;

        if (det != '0) begin
            led_cnt_d = '1;
        end else if (led_cnt_q != '0) begin
            led_cnt_d = led_cnt_q - LED_W'(1);
        end else begin
            led_cnt_d = led_cnt_q;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            ts_q      <= '0;
            stage_q   <= '0;
            prev_q    <= '0;
            edge_q    <= '0;
            out_q     <= '0;
            ovf_q     <= '0;
            led_cnt_q <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                dly_q[c] <= DLY_INIT;
                wr_q[c]  <= '0;
                rd_q[c]  <= '0;
            end
        end else begin
            ts_q      <= ts_d;
            stage_q   <= stage_d;
            prev_q    <= prev_d;
            edge_q    <= edge_d;
            out_q     <= out_d;
            ovf_q     <= ovf_d;
            led_cnt_q <= led_cnt_d;
            for (int c = 0; c < CHANNELS; c++) begin
                dly_q[c] <= dly_d[c];
                wr_q[c]  <= wr_d[c];
                rd_q[c]  <= rd_d[c];
            end
        end
    end

    // Timestamp storage needs no reset: entries are only read between pointers.
    always_ff @(posedge clk_in) begin
        for (int c = 0; c < CHANNELS; c++) begin
            if (push[c]) begin
                mem_q[c][wr_q[c][AW-1:0]] <= ts_q;
            end
        end
    end

    assign out  = out_q;
    assign ovf  = ovf_q;
    assign led0 = (led_cnt_q != '0);
    assign led1 = (ovf_q != '0);

endmodule

// File: tb/tb_delay_line_mc.sv
// Bench for delay_line_mc. An event-level reference model (edge lists keyed by
// absolute cycle number) predicts out/ovf/led0/led1, checked every falling edge,
// plus hand-computed timing expectations at key points.
module tb_delay_line_mc;

    localparam int unsigned CH      = 2;
    localparam int unsigned CNT_W   = 12;
    localparam int unsigned DEPTH   = 16;
    localparam int unsigned DRST    = 165;
    localparam int unsigned LED_W   = 6;
    localparam int unsigned LED_MAX = (1 << LED_W) - 1;
`ifdef DELAY_LINE_MC_SYNC_EN
    localparam int unsigned L = 4;
`else
    localparam int unsigned L = 2;
`endif

    logic             clk_in     = 1'b0;
    logic             rst_n      = 1'b0;
    logic [CH-1:0]    in         = '0;
    logic [CNT_W-1:0] delay_val  = '0;
    logic [0:0]       delay_ch   = '0;
    logic             delay_load = 1'b0;
    logic             ovf_clr    = 1'b0;
    logic [CH-1:0]    out, ovf;
    logic             led0, led1;

    delay_line_mc #(
        .CHANNELS    (CH),
        .CNT_W       (CNT_W),
        .FIFO_DEPTH  (DEPTH),
        .DELAY_RESET (DRST),
        .LED_W       (LED_W)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .in         (in),
        .delay_val  (delay_val),
        .delay_ch   (delay_ch),
        .delay_load (delay_load),
        .ovf_clr    (ovf_clr),
        .out        (out),
        .ovf        (ovf),
        .led0       (led0),
        .led1       (led1)
    );

    always #5 clk_in = ~clk_in;

    // ---------------- reference model ----------------
    int unsigned   cyc = 0;
    logic [CH-1:0] m_lvl = '0, m_lvl_prev = '0, h1 = '0, h2 = '0;
    logic [CH-1:0] m_out = '0, m_ovf = '0;
    logic          m_led = 1'b0;
    bit            led_seen = 1'b0;
    int unsigned   led_t = 0;
    int unsigned   m_dly [CH];
    int unsigned   due_q [CH][$];   // absolute cycle at which out toggles
    int unsigned   samp_q [CH][$];  // cycle an edge entered the input stage

    task automatic model_reset();
        cyc = 0;
        m_lvl = '0; m_lvl_prev = '0; h1 = '0; h2 = '0;
        m_out = '0; m_ovf = '0; m_led = 1'b0; led_seen = 1'b0; led_t = 0;
        for (int c = 0; c < CH; c++) begin
            m_dly[c] = DRST;
            due_q[c].delete();
            samp_q[c].delete();
        end
    endtask

    task automatic model_step();
        logic [CH-1:0] lvl_old, new_lvl;
        int unsigned   p;
        bit            ld, popped, pushing, ovfl;
        cyc++;
        p = cyc;
        lvl_old = m_lvl;
        if ((m_lvl ^ m_lvl_prev) != '0) begin
            led_t = p;
            led_seen = 1'b1;
        end
        for (int c = 0; c < CH; c++) begin
            ld = delay_load && (int'(delay_ch) == c);
            popped = (due_q[c].size() > 0) && (due_q[c][0] == p);
            if (popped) void'(due_q[c].pop_front());
            // an edge is queued two cycles after it reaches the input stage
            pushing = (samp_q[c].size() > 0) && (samp_q[c][0] + 2 == p);
            if (pushing) void'(samp_q[c].pop_front());
            ovfl = pushing && !ld && (due_q[c].size() == DEPTH);
            if (ld || ovfl) begin
                due_q[c].delete();
                samp_q[c].delete();
                m_out[c] = lvl_old[c];
            end else begin
                if (pushing) due_q[c].push_back(p + m_dly[c]);
                if (popped) m_out[c] = ~m_out[c];
            end
            if (ovfl) m_ovf[c] = 1'b1;
            else if (ovf_clr) m_ovf[c] = 1'b0;
            if (ld) m_dly[c] = (delay_val == '0) ? 1 : int'(delay_val);
        end
        if (L == 4) begin
            new_lvl = h2;
            h2 = h1;
            h1 = in;
        end else begin
            new_lvl = in;
        end
        m_lvl_prev = lvl_old;
        m_lvl = new_lvl;
        for (int c = 0; c < CH; c++) begin
            if (new_lvl[c] != lvl_old[c]) samp_q[c].push_back(p);
        end
        m_led = led_seen && ((p - led_t) < LED_MAX);
    endtask

    always @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // ---------------- compare process ----------------
    int    vectors = 0, miscompares = 0, lit_rd = 0, lit_wr = 0;
    string lit_name [256];
    logic [31:0] lit_got [256];
    logic [31:0] lit_exp [256];

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk_in) begin
        check("out", 32'(out), 32'(m_out));
        check("ovf", 32'(ovf), 32'(m_ovf));
        check("led0", 32'(led0), 32'(m_led));
        check("led1", 32'(led1), 32'(m_ovf != '0));
        while (lit_rd < lit_wr) begin
            check(lit_name[lit_rd], lit_got[lit_rd], lit_exp[lit_rd]);
            lit_rd++;
        end
    end

    // ---------------- stimulus ----------------
    task automatic expect_lit(string name, logic [31:0] got, logic [31:0] exp);
        lit_name[lit_wr] = name;
        lit_got[lit_wr]  = got;
        lit_exp[lit_wr]  = exp;
        lit_wr++;
    endtask

    task automatic run(int n);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic load(int ch, int val);
        delay_ch   = 1'(ch);
        delay_val  = CNT_W'(val);
        delay_load = 1'b1;
        run(1);
        delay_load = 1'b0;
    endtask

    task automatic short_pulse();
        in[0] = 1'b1;
        run(1);
        in[0] = 1'b0;
        run(9);
    endtask

    initial begin
        run(3);
        expect_lit("rst_out", 32'(out), 0);
        expect_lit("rst_ovf", 32'(ovf), 0);
        expect_lit("rst_led0", 32'(led0), 0);
        expect_lit("rst_led1", 32'(led1), 0);
        rst_n = 1'b1;
        run(3);

        // Default delay on channel 0, exact shift and width.
        in[0] = 1'b1;
        run(165);
        in[0] = 1'b0;
        run(DRST + L - 165);
        expect_lit("t1_rise_early", 32'(out[0]), 0);
        run(1);
        expect_lit("t1_rise", 32'(out[0]), 1);
        run(164);
        expect_lit("t1_width", 32'(out[0]), 1);
        run(1);
        expect_lit("t1_fall", 32'(out[0]), 0);
        run(1650 - (DRST + L + 1));
        repeat (2) begin
            in[0] = 1'b1;
            run(165);
            in[0] = 1'b0;
            run(1650);
        end
        expect_lit("t1_out1_idle", 32'(out[1]), 0);
        expect_lit("t1_no_ovf", 32'(ovf), 0);

        // Reload channel 1 to 1000 while channel 0 keeps running.
        load(1, 1000);
        run(3);
        in = 2'b11;
        run(100);
        in = 2'b00;
        run(65 + L);
        expect_lit("t2_ch0_early", 32'(out[0]), 0);
        run(1);
        expect_lit("t2_ch0", 32'(out[0]), 1);
        run(1000 - 166);
        expect_lit("t2_ch1_early", 32'(out[1]), 0);
        run(1);
        expect_lit("t2_ch1", 32'(out[1]), 1);
        run(200);

        // Overflow: 16 edges fill the FIFO, the 17th overflows.
        load(0, 3000);
        run(2);
        repeat (8) short_pulse();
        expect_lit("t3_ovf_pre", 32'(ovf[0]), 0);
        in[0] = 1'b1;
        run(1);
        in[0] = 1'b0;
        run(L - 1);
        expect_lit("t3_ovf_early", 32'(ovf[0]), 0);
        run(1);
        expect_lit("t3_ovf_set", 32'(ovf[0]), 1);
        expect_lit("t3_led1", 32'(led1), 1);
        expect_lit("t3_out_level", 32'(out[0]), 0);
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;
        expect_lit("t3_ovf_clr", 32'(ovf[0]), 0);
        expect_lit("t3_led1_clr", 32'(led1), 0);
        run(5);
        // Overflow and ovf_clr in the same cycle: the set wins.
        repeat (8) short_pulse();
        in[0] = 1'b1;
        run(1);
        in[0] = 1'b0;
        run(L - 1);
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;
        expect_lit("t3_set_beats_clr", 32'(ovf[0]), 1);
        ovf_clr = 1'b1;
        run(1);
        ovf_clr = 1'b0;
        expect_lit("t3_ovf_clr2", 32'(ovf[0]), 0);

        // delay_val 0 behaves as 1; single edge stretches led0.
        load(0, 0);
        run(3);
        in[0] = 1'b1;
        run(L + 1);
        expect_lit("t4_d1_early", 32'(out[0]), 0);
        run(1);
        expect_lit("t4_d1", 32'(out[0]), 1);
        in[0] = 1'b0;
        run(100);
        in[1] = 1'b1;
        run(L - 1);
        expect_lit("t4_led_before", 32'(led0), 0);
        run(LED_MAX);
        expect_lit("t4_led_last", 32'(led0), 1);
        run(1);
        expect_lit("t4_led_off", 32'(led0), 0);

        // Maximum delay spans a timestamp wrap.
        load(0, 4095);
        run(3);
        in[0] = 1'b1;
        run(4095 + L);
        expect_lit("t5_wrap_early", 32'(out[0]), 0);
        run(1);
        expect_lit("t5_wrap", 32'(out[0]), 1);

        // Reset mid-operation with three edges pending.
        load(0, 50);
        in[0] = 1'b0;
        run(2);
        in[0] = 1'b1;
        run(2);
        in[0] = 1'b0;
        run(2);
        expect_lit("t6_pre_rst", 32'(out[0]), 1);
        #2;
        rst_n = 1'b0;
        in = '0;
        #1;
        expect_lit("t6_rst_now", 32'(out), 0);
        run(3);
        rst_n = 1'b1;
        run(200);
        expect_lit("t6_no_stale", 32'(out), 0);

        // Input already high at reset release counts as a rising edge.
        rst_n = 1'b0;
        run(2);
        in[0] = 1'b1;
        run(2);
        rst_n = 1'b1;
        run(DRST + L);
        expect_lit("t7_rel_early", 32'(out[0]), 0);
        run(1);
        expect_lit("t7_rel", 32'(out[0]), 1);

        run(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
